// File: rtl/true_dpr_pkg.sv
// true_dpr_pkg: shared definitions for the true dual-port RAM.
//   rw_mode_e   - same-port read-during-write behaviour (RW_MODE parameter values)
//   byte_merge  - overlays the enabled bytes of a new word onto an old word
//   coll_check  - classifies a cross-port same-address access pair
package true_dpr_pkg;

    typedef enum logic {
        RW_READ_FIRST  = 1'b0,
        RW_WRITE_FIRST = 1'b1
    } rw_mode_e;

    // Widest word byte_merge handles; callers zero-extend in and truncate out.
    localparam int MERGE_MAX    = 256;
    localparam int MERGE_MAX_BE = MERGE_MAX / 8;

    typedef struct packed {
        logic ww;
        logic rw;
    } coll_t;

    // Walks the word one byte at a time from the bottom, shifting the chosen
    // byte in at the top so no variable-indexed selects are needed.
    function automatic logic [MERGE_MAX-1:0] byte_merge(
        input logic [MERGE_MAX-1:0]    old_word,
        input logic [MERGE_MAX-1:0]    new_word,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX-1:0]    o;
        logic [MERGE_MAX-1:0]    n;
        logic [MERGE_MAX-1:0]    res;
        logic [MERGE_MAX_BE-1:0] b;
        o   = old_word;
        n   = new_word;
        b   = be;
        res = '0;
        for (int unsigned i = 0; i < MERGE_MAX_BE; i++) begin
            res = {(b[0] ? n[7:0] : o[7:0]), res[MERGE_MAX-1:8]};
            o   = o >> 8;
            n   = n >> 8;
            b   = b >> 1;
        end
        return res;
    endfunction

    // wr_x already includes the port enable.
    function automatic coll_t coll_check(
        input logic acc_a,
        input logic wr_a,
        input logic acc_b,
        input logic wr_b,
        input logic same_addr
    );
        coll_t c;
        c.ww = same_addr & wr_a & wr_b;
        c.rw = same_addr & acc_a & acc_b & (wr_a ^ wr_b);
        return c;
    endfunction

endpackage

// File: rtl/true_dpr_pipe_out.sv
// dpr_out_pipe: per-port read-data output pipeline, RD_LATENCY stages deep.
//   clk, rst_n  - clock, asynchronous active-low reset (clears all stages)
//   acc         - an access was enabled on this edge
//   rdata       - word to return for that access
//   dout        - read data, holds its last value between accesses
//   dvalid      - dout carries a fresh access result this cycle
module dpr_out_pipe #(
    parameter int DATA_SIZE  = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 acc,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dvalid
);

    for (genvar s = 0; s < RD_LATENCY; s++) begin : g_stage
        logic [DATA_SIZE-1:0] data;
        logic                 vld;

        if (s == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data <= '0;
                    vld  <= 1'b0;
                end else begin
                    vld <= acc;
                    if (acc) data <= rdata;
                end
            end
        end else begin : g_next
            // Later stages only load behind a valid word, so idle cycles keep dout steady.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data <= '0;
                    vld  <= 1'b0;
                end else begin
                    vld <= g_stage[s-1].vld;
                    if (g_stage[s-1].vld) data <= g_stage[s-1].data;
                end
            end
        end
    end

    assign dout   = g_stage[RD_LATENCY-1].data;
    assign dvalid = g_stage[RD_LATENCY-1].vld;

endmodule

// File: rtl/true_dpr_pipe.sv
// true_dpr_pipe: true dual-port RAM, one clock, byte enables, selectable
// same-port read-during-write mode, 1- or 2-cycle read latency.
//   clk, rst_n                   - clock, asynchronous active-low reset
//   en_x, we_x, be_x, addr_x     - port x access enable, write, byte enables, address
//   din_x                        - port x write data
//   dout_x, dvalid_x             - port x read data and its valid strobe
//   coll_ww, coll_rw             - registered same-address collision pulses
// Port A wins bytes written by both ports; a port only reading a word the other
// port writes in the same cycle always sees the pre-write word.
module true_dpr_pipe
    import true_dpr_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_SIZE  = 32,
    parameter int BE_SIZE    = DATA_SIZE / 8,
    parameter int RAM_SIZE   = 1 << ADDR_SIZE,
    parameter int RD_LATENCY = 1,
    parameter int RW_MODE    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_a,
    input  logic                 we_a,
    input  logic [BE_SIZE-1:0]   be_a,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [DATA_SIZE-1:0] din_a,
    output logic [DATA_SIZE-1:0] dout_a,
    output logic                 dvalid_a,
    input  logic                 en_b,
    input  logic                 we_b,
    input  logic [BE_SIZE-1:0]   be_b,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [DATA_SIZE-1:0] din_b,
    output logic [DATA_SIZE-1:0] dout_b,
    output logic                 dvalid_b,
    output logic                 coll_ww,
    output logic                 coll_rw
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("true_dpr_pipe: RD_LATENCY must be 1 or 2");
    end
    if (RW_MODE != 0 && RW_MODE != 1) begin : g_bad_mode
        $error("true_dpr_pipe: RW_MODE must be 0 or 1");
    end
    if (DATA_SIZE % 8 != 0 || DATA_SIZE > MERGE_MAX || BE_SIZE != DATA_SIZE / 8) begin : g_bad_width
        $error("true_dpr_pipe: DATA_SIZE must be a multiple of 8 within the merge range");
    end

    localparam bit WRITE_FIRST = (RW_MODE == int'(RW_WRITE_FIRST));

    function automatic logic [DATA_SIZE-1:0] merge(
        input logic [DATA_SIZE-1:0] old_word,
        input logic [DATA_SIZE-1:0] new_word,
        input logic [BE_SIZE-1:0]   be
    );
        return DATA_SIZE'(byte_merge(MERGE_MAX'(old_word), MERGE_MAX'(new_word),
                                     MERGE_MAX_BE'(be)));
    endfunction

    logic [DATA_SIZE-1:0] mem [RAM_SIZE];

    logic                 wr_a;
    logic                 wr_b;
    logic                 same_addr;
    logic                 mem_we_a;
    logic                 mem_we_b;
    logic [DATA_SIZE-1:0] old_a;
    logic [DATA_SIZE-1:0] old_b;
    logic [DATA_SIZE-1:0] wdata_a;
    logic [DATA_SIZE-1:0] wdata_b;
    logic [DATA_SIZE-1:0] rdata_a;
    logic [DATA_SIZE-1:0] rdata_b;
    coll_t                coll;

    always_comb begin
        wr_a      = en_a & we_a;
        wr_b      = en_b & we_b;
        same_addr = (addr_a == addr_b);
        old_a     = mem[addr_a];
        old_b     = mem[addr_b];
        wdata_b   = merge(old_b, din_b, be_b);
        // A double write to one word is folded into a single array write by
        // port A: B's bytes go in first and A's bytes overlay them.
        if (wr_b && same_addr) wdata_a = merge(wdata_b, din_a, be_a);
        else                   wdata_a = merge(old_a, din_a, be_a);
        mem_we_a  = wr_a & rst_n;
        mem_we_b  = wr_b & rst_n & ~(wr_a & same_addr);
        rdata_a   = (WRITE_FIRST && wr_a) ? wdata_a : old_a;
        rdata_b   = old_b;
        if (WRITE_FIRST && wr_b) rdata_b = (wr_a && same_addr) ? wdata_a : wdata_b;
        coll      = coll_check(en_a, wr_a, en_b, wr_b, same_addr);
    end

    always_ff @(posedge clk) begin
        if (mem_we_a) mem[addr_a] <= wdata_a;
        if (mem_we_b) mem[addr_b] <= wdata_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_ww <= 1'b0;
            coll_rw <= 1'b0;
        end else begin
            coll_ww <= coll.ww;
            coll_rw <= coll.rw;
        end
    end

    dpr_out_pipe #(
        .DATA_SIZE (DATA_SIZE),
        .RD_LATENCY(RD_LATENCY)
    ) u_pipe_a (
        .clk   (clk),
        .rst_n (rst_n),
        .acc   (en_a),
        .rdata (rdata_a),
        .dout  (dout_a),
        .dvalid(dvalid_a)
    );

    dpr_out_pipe #(
        .DATA_SIZE (DATA_SIZE),
        .RD_LATENCY(RD_LATENCY)
    ) u_pipe_b (
        .clk   (clk),
        .rst_n (rst_n),
        .acc   (en_b),
        .rdata (rdata_b),
        .dout  (dout_b),
        .dvalid(dvalid_b)
    );

endmodule

// File: tb/tb_true_dpr_pipe.sv
// tb_true_dpr_pipe: drives two RAM instances with the same directed stimulus,
// index 0 = RD_LATENCY 1 / READ_FIRST, index 1 = RD_LATENCY 2 / WRITE_FIRST,
// and checks both against a word-level model of the memory every cycle.
module tb_true_dpr_pipe;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic [31:0] dout_a_c [2];
    logic [31:0] dout_b_c [2];
    logic        dvalid_a_c [2];
    logic        dvalid_b_c [2];
    logic        coll_ww_c [2];
    logic        coll_rw_c [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    true_dpr_pipe #(.ADDR_SIZE(8), .DATA_SIZE(32), .RD_LATENCY(1), .RW_MODE(0)) u_dut_l1_rf (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a_c[0]), .dvalid_a(dvalid_a_c[0]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b_c[0]), .dvalid_b(dvalid_b_c[0]),
        .coll_ww(coll_ww_c[0]), .coll_rw(coll_rw_c[0])
    );

    true_dpr_pipe #(.ADDR_SIZE(8), .DATA_SIZE(32), .RD_LATENCY(2), .RW_MODE(1)) u_dut_l2_wf (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a_c[1]), .dvalid_a(dvalid_a_c[1]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b_c[1]), .dvalid_b(dvalid_b_c[1]),
        .coll_ww(coll_ww_c[1]), .coll_rw(coll_rw_c[1])
    );

    // ---------------- model ----------------
    logic [31:0] m_mem [256];
    bit          m_known [256];
    bit          pv [2][2][2];          // [cfg][port][stage]
    logic [31:0] pd [2][2][2];
    bit          pk [2][2][2];
    logic [31:0] hd [2][2];             // expected dout per cfg/port
    bit          hk [2][2];             // hd is a defined value
    bit          e_ww, e_rw;
    bit          pen [2], pwr [2], kbef [2], kaft [2];
    logic [31:0] pbef [2], paft [2];

    function automatic logic [31:0] bmask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++) begin
                    for (int s = 0; s < 2; s++) begin
                        pv[c][p][s] = 0; pd[c][p][s] = '0; pk[c][p][s] = 1;
                    end
                    hd[c][p] = '0; hk[c][p] = 1;
                end
            e_ww = 0; e_rw = 0;
        end else begin
            pen[0] = en_a; pwr[0] = en_a && we_a;
            pen[1] = en_b; pwr[1] = en_b && we_b;
            pbef[0] = m_mem[addr_a]; kbef[0] = m_known[addr_a];
            pbef[1] = m_mem[addr_b]; kbef[1] = m_known[addr_b];
            // B lands first, A last: A owns bytes both ports enable.
            if (pwr[1]) begin
                m_mem[addr_b] = (m_mem[addr_b] & ~bmask(be_b)) | (din_b & bmask(be_b));
                if (be_b == 4'hF) m_known[addr_b] = 1;
            end
            if (pwr[0]) begin
                m_mem[addr_a] = (m_mem[addr_a] & ~bmask(be_a)) | (din_a & bmask(be_a));
                if (be_a == 4'hF) m_known[addr_a] = 1;
            end
            paft[0] = m_mem[addr_a]; kaft[0] = m_known[addr_a];
            paft[1] = m_mem[addr_b]; kaft[1] = m_known[addr_b];
            e_ww = pwr[0] && pwr[1] && (addr_a == addr_b);
            e_rw = en_a && en_b && (addr_a == addr_b) && (pwr[0] != pwr[1]);
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++) begin
                    if (c == 1) begin
                        pv[c][p][1] = pv[c][p][0]; pd[c][p][1] = pd[c][p][0]; pk[c][p][1] = pk[c][p][0];
                    end
                    pv[c][p][0] = pen[p];
                    pd[c][p][0] = (pwr[p] && c == 1) ? paft[p] : pbef[p];
                    pk[c][p][0] = (pwr[p] && c == 1) ? kaft[p] : kbef[p];
                    if (pv[c][p][c]) begin
                        hd[c][p] = pd[c][p][c]; hk[c][p] = pk[c][p][c];
                    end
                end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model (last stage of cfg c is index c).
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("dvalid_a[%0d]", c), {31'b0, dvalid_a_c[c]}, {31'b0, pv[c][0][c]});
            chk($sformatf("dvalid_b[%0d]", c), {31'b0, dvalid_b_c[c]}, {31'b0, pv[c][1][c]});
            if (hk[c][0]) chk($sformatf("dout_a[%0d]", c), dout_a_c[c], hd[c][0]);
            if (hk[c][1]) chk($sformatf("dout_b[%0d]", c), dout_b_c[c], hd[c][1]);
            chk($sformatf("coll_ww[%0d]", c), {31'b0, coll_ww_c[c]}, {31'b0, e_ww});
            chk($sformatf("coll_rw[%0d]", c), {31'b0, coll_rw_c[c]}, {31'b0, e_rw});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic ea, input logic wa, input logic [3:0] bea, input logic [7:0] aa,
                       input logic [31:0] da, input logic eb, input logic wb, input logic [3:0] beb,
                       input logic [7:0] ab, input logic [31:0] db);
        en_a = ea; we_a = wa; be_a = bea; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; be_b = beb; addr_b = ab; din_b = db;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        en_a = 0; we_a = 0; en_b = 0; we_b = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        en_a = 0; we_a = 0; be_a = '0; addr_a = '0; din_a = '0;
        en_b = 0; we_b = 0; be_b = '0; addr_b = '0; din_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout_a0", dout_a_c[0], 32'h0);
        chk("rst_dvalid_a1", {31'b0, dvalid_a_c[1]}, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // full write then read on A
        cyc(1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 0, 4'h0, 8'h00, 32'h0);
        cyc(1, 0, 4'h0, 8'h10, 32'h0,        0, 0, 4'h0, 8'h00, 32'h0);
        chk("lit_rd10_l1", dout_a_c[0], 32'hDEADBEEF);
        chk("lit_rd10_l1_v", {31'b0, dvalid_a_c[0]}, 32'h1);
        cyc(1, 1, 4'h0, 8'h10, 32'hFFFFFFFF, 0, 0, 4'h0, 8'h00, 32'h0); // be=0: no change
        chk("lit_rd10_l2", dout_a_c[1], 32'hDEADBEEF);
        chk("lit_rd10_l2_v", {31'b0, dvalid_a_c[1]}, 32'h1);

        // partial write on B
        cyc(0, 0, 4'h0, 8'h00, 32'h0, 1, 1, 4'hF, 8'h20, 32'h11223344);
        cyc(0, 0, 4'h0, 8'h00, 32'h0, 1, 1, 4'h5, 8'h20, 32'hAABBCCDD);
        cyc(0, 0, 4'h0, 8'h00, 32'h0, 1, 0, 4'h0, 8'h20, 32'h0);
        chk("lit_be5_l1", dout_b_c[0], 32'h11BB33DD);
        idle(1);
        chk("lit_be5_l2", dout_b_c[1], 32'h11BB33DD);

        // same-port read-during-write
        cyc(1, 1, 4'hF, 8'h03, 32'h77, 0, 0, 4'h0, 8'h00, 32'h0);
        cyc(1, 1, 4'hF, 8'h03, 32'h55, 0, 0, 4'h0, 8'h00, 32'h0);
        chk("lit_rf_old", dout_a_c[0], 32'h77);
        idle(1);
        chk("lit_wf_new", dout_a_c[1], 32'h55);

        // write-write collision
        cyc(1, 1, 4'h1, 8'h40, 32'h000000FF, 1, 1, 4'hF, 8'h40, 32'h12345678);
        chk("lit_ww_pulse", {31'b0, coll_ww_c[0]}, 32'h1);
        cyc(1, 0, 4'h0, 8'h40, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
        chk("lit_ww_clear", {31'b0, coll_ww_c[1]}, 32'h0);
        chk("lit_ww_word", dout_a_c[0], 32'h123456FF);
        idle(1);

        // read-write collision
        cyc(1, 1, 4'hF, 8'h07, 32'h0A, 0, 0, 4'h0, 8'h00, 32'h0);
        cyc(1, 0, 4'h0, 8'h07, 32'h0,  1, 1, 4'hF, 8'h07, 32'h0B);
        chk("lit_rw_pulse", {31'b0, coll_rw_c[1]}, 32'h1);
        chk("lit_rw_old", dout_a_c[0], 32'h0A);
        cyc(1, 0, 4'h0, 8'h07, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
        chk("lit_rw_old_l2", dout_a_c[1], 32'h0A);
        chk("lit_rw_new", dout_a_c[0], 32'h0B);
        idle(1);

        // independent addresses, back-to-back
        cyc(1, 1, 4'hF, 8'h50, 32'hCAFE0001, 1, 1, 4'hF, 8'h51, 32'hBEEF0002);
        cyc(1, 0, 4'h0, 8'h51, 32'h0,        1, 0, 4'h0, 8'h50, 32'h0);
        chk("lit_xaddr", dout_a_c[0], 32'hBEEF0002);
        cyc(1, 0, 4'h0, 8'h50, 32'h0,        1, 0, 4'h0, 8'h51, 32'h0);
        idle(2);

        // reset during an in-flight stream (LAT=2 instance)
        cyc(1, 0, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
        cyc(1, 0, 4'h0, 8'h20, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
        chk("lit_pre_rst_v", {31'b0, dvalid_a_c[1]}, 32'h1);
        chk("lit_pre_rst_d", dout_a_c[1], 32'hDEADBEEF);
        en_a = 1; we_a = 1; be_a = 4'hF; addr_a = 8'h10; din_a = 32'h0; // must not land
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_v", {31'b0, dvalid_a_c[1]}, 32'h0);
        chk("lit_rst_d", dout_a_c[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        cyc(1, 0, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
        chk("lit_kept_l1", dout_a_c[0], 32'hDEADBEEF);
        idle(1);
        chk("lit_kept_l2", dout_a_c[1], 32'hDEADBEEF);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/true_dpr_pipe.md
Name: true_dpr_pipe

Overview:
Parametrised true dual-port RAM and the successor to the single-mode true_dpr.
- Two independent read/write ports, A and B, on one clock.
- Per-byte write enables and a selectable same-port read-during-write mode.
- Configurable read latency of 1 or 2 cycles, with a data-valid strobe per port.
- Deterministic cross-port collision resolution, with registered collision flags for system monitoring.
- Used as the shared buffer between two independent masters in the datapath.

Parameters:
- ADDR_SIZE, 8, address width per port.
- DATA_SIZE, 32, word width; must be a multiple of 8.
- BE_SIZE, DATA_SIZE/8, byte-enable width (derived; do not override).
- RAM_SIZE, 1 << ADDR_SIZE, number of words.
- RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2.
- RW_MODE, 0, same-port read-during-write: 0 = READ_FIRST, 1 = WRITE_FIRST.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en_a, in, 1, port A access enable.
- we_a, in, 1, port A write (valid only with en_a).
- be_a, in, BE_SIZE, port A byte enables for writes.
- addr_a, in, ADDR_SIZE, port A address.
- din_a, in, DATA_SIZE, port A write data.
- dout_a, out, DATA_SIZE, port A read data.
- dvalid_a, out, 1, port A read data valid.
- en_b, we_b, be_b, addr_b, din_b, dout_b, dvalid_b: same as port A, for port B.
- coll_ww, out, 1, write-write same-address collision flag (registered pulse).
- coll_rw, out, 1, read-write cross-port same-address collision flag (registered pulse).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: dout_a, dout_b = 0; dvalid_a, dvalid_b = 0; coll_ww, coll_rw = 0; all pipeline stages = 0.
- Memory array: not cleared by reset.
- Write timing: a write occurs at the rising edge when en_x=1, we_x=1 and rst_n=1. Only bytes with be_x[i]=1 are updated.
- we_x=1 with be_x=0: no memory change, but it still counts as an access (dvalid is produced).
- Read access: every enabled access (read or write) produces read data.
  - Data and dvalid_x appear RD_LATENCY cycles after the enabling edge.
  - RD_LATENCY=1: data is registered at array output.
  - RD_LATENCY=2: one further output register is added.
- Idle ports: dout_x holds its last value when no access emerges from the pipe; dvalid_x=0 that cycle.
- Back-to-back: accesses every cycle give a full-throughput stream, with no bubbles in either latency setting.
- Same-port write, READ_FIRST: returned data is the pre-write word.
- Same-port write, WRITE_FIRST: returned data is the post-write word (old bytes merged with the enabled new bytes).
- Cross-port write-write, same address, same cycle:
  - Bytes enabled on both ports take port A data.
  - Bytes enabled only on B take B data.
  - coll_ww=1 in the following cycle, for one cycle.
- Cross-port read-write, same address, same cycle: the reading port, or the other port's read-back, always returns the pre-write word regardless of RW_MODE. coll_rw=1 in the following cycle.
- Both ports writing the same address: each port's read-back follows its own RW_MODE rule against the final merged word for WRITE_FIRST, or the pre-write word for READ_FIRST.
- Different addresses: no interaction between ports; no flags.
- Address width: addresses use the full ADDR_SIZE range; no out-of-range case exists; there is no wrap logic.
- Reset asserted mid-operation:
  - In-flight pipeline reads are discarded (dvalid forced low immediately, asynchronously).
  - No write occurs on any edge while rst_n=0.
  - After deassertion, the first access behaves as from idle.
- Illegal RD_LATENCY: fails elaboration via a generate-time check.

Decomposition:
- Package true_dpr_pkg:
  - RW_READ_FIRST=0 and RW_WRITE_FIRST=1 constants.
  - Byte-merge function (old word, new word, byte enables) -> merged word.
  - Collision-compare helper.
- Sub-module dpr_out_pipe: per-port output pipeline (RD_LATENCY stages of data plus valid, async reset). Instantiated twice.
- Array, write arbitration and collision logic stay in the top-level module.

Test Plan:
- Reset, then port A writes 0xDEADBEEF to addr 0x10 with be=0xF, then reads 0x10 → dout_a=0xDEADBEEF with dvalid_a high exactly RD_LATENCY cycles after the read edge; dout_a=0 and dvalid_a=0 throughout reset.
- Addr 0x20 holds 0x11223344; port B writes 0xAABBCCDD with be=0b0101 → subsequent read gives 0x11BB33DD.
- RW_MODE=0, port A writes 0x55 over 0x77 at addr 3 → read-back shows 0x77. RW_MODE=1, same stimulus → read-back shows 0x55.
- Same cycle: A writes 0x000000FF with be=0x1, B writes 0x12345678 with be=0xF, both to addr 0x40 → word = 0x123456FF; coll_ww pulses one cycle later.
- A reads addr 7 (holding 0x0A) while B writes 0x0B to addr 7 in the same cycle → dout_a=0x0A, coll_rw pulses one cycle later; the next A read returns 0x0B.
- RD_LATENCY=2, reads issued on 3 consecutive cycles, then rst_n pulsed low after the second → dvalid_a drops immediately, no stale data emerges after release, and the array retains its contents.
